bounce_ctrl: RTL and testbench
==============================

Name: bounce_ctrl

Overview:
- Parametrised vertical gravity/bounce engine for one on-screen sprite, successor to the fixed IDLE/DOWN/UP/BOTTOM/BOUNCE constant set in the VGA package.
- Generalises floor, position width, step rate, energy loss and stop threshold, and adds a bottom-hold (squash) phase and a bounce counter.
- Sits between the mouse/start logic and the rectangle-draw stage; its y_pos drives the sprite's top edge, default 800x600 @ 40 MHz.

Parameters:
- Y_W, 10, width of position
- VEL_W, 8, width of velocity (unsigned magnitude)
- Y_FLOOR, 537, lowest allowed y_pos (VER_PIXELS - sprite height)
- TICK_DIV, 1000000, clk cycles per physics step (>=2)
- LOSS_SHIFT, 2, bounce loss: vel_new = vel - (vel >> LOSS_SHIFT)
- V_MIN, 2, post-bounce velocity below which motion stops
- BOTTOM_HOLD, 4, ticks spent in BOTTOM before BOUNCE (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle launch pulse
- y_init  in  Y_W  launch position, sampled with start
- y_pos  out  Y_W  current sprite top y
- busy  out  1  high in any state except IDLE
- state_o  out  3  current state code (IDLE=0, DOWN=1, UP=2, BOTTOM=3, BOUNCE=4)
- bounce_cnt  out  8  bounces since last launch, saturates at 255

Behaviour:
- Reset (async, any time incl. mid-flight): state IDLE, y_pos 0, vel 0, busy 0, bounce_cnt 0, tick counter 0, hold counter 0. All outputs registered.
- Tick: counter 0..TICK_DIV-1 runs only when busy; tick is asserted in the cycle the counter equals TICK_DIV-1, then the counter wraps to 0. Counter clears on accepted start and on entry to IDLE.
- IDLE: y_pos holds. On start: y_pos <= min(y_init, Y_FLOOR), vel <= 0, bounce_cnt <= 0, go DOWN (1-cycle latency). Without the optional feature, start outside IDLE is ignored.
- DOWN, on tick: v' = vel+1, saturating at 2^VEL_W-1; y_next = y_pos + v' computed at Y_W+VEL_W+1 bits. If y_next >= Y_FLOOR: y_pos <= Y_FLOOR, vel <= v', hold <= 0, go BOTTOM. Otherwise y_pos <= y_next, vel <= v'.
- BOTTOM: y_pos = Y_FLOOR; hold increments per tick; on tick with hold = BOTTOM_HOLD-1, go BOUNCE.
- BOUNCE (exactly one clk, no tick needed): vel <= vel - (vel >> LOSS_SHIFT); bounce_cnt +1 saturating. If new vel < V_MIN: vel <= 0, go IDLE (y_pos stays Y_FLOOR). Otherwise go UP.
- UP, on tick: if vel == 0, go DOWN (y unchanged). Otherwise y_pos <= (y_pos > vel) ? y_pos-vel : 0 and vel <= vel-1; if clamped at 0, vel <= 0.
- Non-tick cycles in DOWN/UP/BOTTOM: no state or position change.
- y_init = Y_FLOOR: first DOWN tick moves to BOTTOM with vel 1, which is < V_MIN at the default, so the sprite returns to IDLE after BOTTOM_HOLD ticks with bounce_cnt 1.

Optional Feature:
- Macro BOUNCE_RESTART_EN.
- Defined: start is accepted in every state. Same actions as from IDLE (reload y, vel 0, bounce_cnt 0, tick/hold cleared, go DOWN), and it takes priority over any same-cycle tick transition.
- Undefined: start is honoured only in IDLE.

Test Plan:
(TB params for all scenarios: TICK_DIV=4, Y_FLOOR=20, LOSS_SHIFT=1, V_MIN=2, BOTTOM_HOLD=2.)
- Reset: assert rst mid-DOWN at y_pos=6 -> same-cycle async clear to IDLE, y_pos 0, busy 0, bounce_cnt 0.
- Launch y_init=0 -> after each tick y_pos=1,3,6,10,15, then the 6th tick gives 20 with state BOTTOM. After 2 ticks, BOUNCE for 1 clk with vel 6->3 and bounce_cnt=1, then UP: y_pos=17,15,14, then DOWN.
- Clamp: y_init=30 -> y_pos=20 after start. First tick -> BOTTOM, vel 1. After hold, BOUNCE -> vel 1 < 2 -> IDLE with busy 0 and bounce_cnt 1.
- Stop condition: run from y_init=0 until idle -> busy falls, y_pos=20, bounce_cnt > 1, no further y change over 100 cycles.
- Start while busy (macro off): pulse start mid-UP -> trajectory unchanged.
- Start while busy (macro on): pulse start mid-UP -> next cycle y_pos=y_init, bounce_cnt=0, state DOWN.

Source files
------------

// File: rtl/bounce_ctrl.sv
// bounce_ctrl: vertical gravity/bounce engine for one sprite (IDLE/DOWN/UP/BOTTOM/BOUNCE).
// Ports: clk, rst (async, active-high), start/y_init launch; y_pos, busy, state_o, bounce_cnt (all registered).
// Optional macro BOUNCE_RESTART_EN: when defined, start relaunches from any state, not only IDLE.
module bounce_ctrl #(
  parameter int Y_W         = 10,
  parameter int VEL_W       = 8,
  parameter int Y_FLOOR     = 537,
  parameter int TICK_DIV    = 1000000,
  parameter int LOSS_SHIFT  = 2,
  parameter int V_MIN       = 2,
  parameter int BOTTOM_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [Y_W-1:0] y_init,
  output logic [Y_W-1:0] y_pos,
  output logic           busy,
  output logic [2:0]     state_o,
  output logic [7:0]     bounce_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DOWN   = 3'd1;
  localparam logic [2:0] S_UP     = 3'd2;
  localparam logic [2:0] S_BOTTOM = 3'd3;
  localparam logic [2:0] S_BOUNCE = 3'd4;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(BOTTOM_HOLD + 1);
  // Wide enough that y_pos + velocity can never wrap.
  localparam int SW = Y_W + VEL_W + 1;

  localparam logic [Y_W-1:0]   FLOOR_Y   = Y_W'(Y_FLOOR);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0]    HOLD_LAST = HW'(BOTTOM_HOLD - 1);
  localparam logic [VEL_W-1:0] VEL_MAX   = {VEL_W{1'b1}};
  localparam logic [VEL_W-1:0] VMIN_V    = VEL_W'(V_MIN);

  logic [2:0]       state, state_n;
  logic [VEL_W-1:0] vel, vel_n;
  logic [Y_W-1:0]   y_n;
  logic [7:0]       cnt_n;
  logic [TW-1:0]    tick_cnt;
  logic [HW-1:0]    hold, hold_n;
  logic             tick, tick_clr, accept;
  logic [VEL_W-1:0] v_inc, v_loss;
  logic [SW-1:0]    y_sum;

  assign state_o = state;
  assign tick    = busy && (tick_cnt == TICK_LAST);

`ifdef BOUNCE_RESTART_EN
  assign accept = start;
`else
  assign accept = start && (state == S_IDLE);
`endif

  always_comb begin
    state_n  = state;
    y_n      = y_pos;
    vel_n    = vel;
    cnt_n    = bounce_cnt;
    hold_n   = hold;
    v_inc    = (vel == VEL_MAX) ? vel : vel + VEL_W'(1);
    v_loss   = vel - (vel >> LOSS_SHIFT);
    y_sum    = SW'(y_pos) + SW'(v_inc);

    // A launch overrides whatever the current state would do this cycle.
    if (accept) begin
      y_n     = (y_init > FLOOR_Y) ? FLOOR_Y : y_init;
      vel_n   = '0;
      cnt_n   = '0;
      hold_n  = '0;
      state_n = S_DOWN;
    end else begin
      case (state)
        S_DOWN: begin
          if (tick) begin
            vel_n = v_inc;
            if (y_sum >= SW'(Y_FLOOR)) begin
              y_n     = FLOOR_Y;
              hold_n  = '0;
              state_n = S_BOTTOM;
            end else begin
              y_n = y_sum[Y_W-1:0];
            end
          end
        end
        S_BOTTOM: begin
          if (tick) begin
            if (hold == HOLD_LAST) state_n = S_BOUNCE;
            else                   hold_n  = hold + HW'(1);
          end
        end
        S_BOUNCE: begin
          cnt_n = (bounce_cnt == 8'hFF) ? bounce_cnt : bounce_cnt + 8'd1;
          if (v_loss < VMIN_V) begin
            vel_n   = '0;
            state_n = S_IDLE;
          end else begin
            vel_n   = v_loss;
            state_n = S_UP;
          end
        end
        S_UP: begin
          if (tick) begin
            if (vel == '0) begin
              state_n = S_DOWN;
            end else if (SW'(y_pos) > SW'(vel)) begin
              // vel < y_pos here, so it fits in Y_W bits.
              y_n   = Y_W'(SW'(y_pos) - SW'(vel));
              vel_n = vel - VEL_W'(1);
            end else begin
              y_n   = '0;
              vel_n = '0;
            end
          end
        end
        default: state_n = state;
      endcase
    end

    tick_clr = accept || (state_n == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      y_pos      <= '0;
      vel        <= '0;
      busy       <= 1'b0;
      bounce_cnt <= '0;
      tick_cnt   <= '0;
      hold       <= '0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != S_IDLE);
      y_pos      <= y_n;
      vel        <= vel_n;
      bounce_cnt <= cnt_n;
      hold       <= hold_n;
      if (tick_clr)  tick_cnt <= '0;
      else if (busy) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_bounce_ctrl.sv
module tb_bounce_ctrl;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DOWN   = 3'd1;
  localparam logic [2:0] ST_UP     = 3'd2;
  localparam logic [2:0] ST_BOTTOM = 3'd3;
  localparam logic [2:0] ST_BOUNCE = 3'd4;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] y;
    logic [7:0] cnt;
    logic       bsy;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] y_init = '0;
  logic [9:0] y_pos;
  logic       busy;
  logic [2:0] state_o;
  logic [7:0] bounce_cnt;

  int   checks = 0;
  int   failures = 0;
  ev_t  exp_q[$];
  ev_t  last;

  always #5 clk = ~clk;

  bounce_ctrl #(
    .Y_W(10), .VEL_W(8), .Y_FLOOR(20), .TICK_DIV(4),
    .LOSS_SHIFT(1), .V_MIN(2), .BOTTOM_HOLD(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .y_init(y_init),
    .y_pos(y_pos), .busy(busy), .state_o(state_o), .bounce_cnt(bounce_cnt)
  );

  function automatic ev_t mk(input logic [2:0] s, input int y, input int c);
    ev_t e;
    e.st  = s;
    e.y   = 10'(y);
    e.cnt = 8'(c);
    e.bsy = (s != ST_IDLE);
    return e;
  endfunction

  function automatic ev_t cur();
    ev_t e;
    e.st  = state_o;
    e.y   = y_pos;
    e.cnt = bounce_cnt;
    e.bsy = busy;
    return e;
  endfunction

  task automatic push(input logic [2:0] s, input int y, input int c);
    exp_q.push_back(mk(s, y, c));
  endtask

  // Called at a falling edge; start is seen by exactly one rising edge.
  task automatic pulse_start(input int y);
    start  = 1'b1;
    y_init = 10'(y);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic test_reset();
    ev_t o;
    repeat (2) @(negedge clk);
    o = cur();
    checks++;
    if (o !== mk(ST_IDLE, 0, 0)) begin
      failures++;
      $display("FAIL reset_held: got st=%0d y=%0d cnt=%0d busy=%0d, want st=0 y=0 cnt=0 busy=0",
               o.st, o.y, o.cnt, o.bsy);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    o = cur();
    checks++;
    if (o !== mk(ST_IDLE, 0, 0)) begin
      failures++;
      $display("FAIL reset_release_idle: got st=%0d y=%0d cnt=%0d busy=%0d, want idle at 0",
               o.st, o.y, o.cnt, o.bsy);
    end
  endtask

  // Full flight from y=0 down to rest; every change of outputs is one scoreboard entry.
  task automatic test_launch();
    ev_t o, e;
    int  budget, n;
    exp_q.delete();
    push(ST_DOWN, 0, 0);    push(ST_DOWN, 1, 0);    push(ST_DOWN, 3, 0);
    push(ST_DOWN, 6, 0);    push(ST_DOWN, 10, 0);   push(ST_DOWN, 15, 0);
    push(ST_BOTTOM, 20, 0); push(ST_BOUNCE, 20, 0); push(ST_UP, 20, 1);
    push(ST_UP, 17, 1);     push(ST_UP, 15, 1);     push(ST_UP, 14, 1);
    push(ST_DOWN, 14, 1);   push(ST_DOWN, 15, 1);   push(ST_DOWN, 17, 1);
    push(ST_BOTTOM, 20, 1); push(ST_BOUNCE, 20, 1); push(ST_UP, 20, 2);
    push(ST_UP, 18, 2);     push(ST_UP, 17, 2);     push(ST_DOWN, 17, 2);
    push(ST_DOWN, 18, 2);   push(ST_BOTTOM, 20, 2); push(ST_BOUNCE, 20, 2);
    push(ST_IDLE, 20, 3);
    last = cur();
    pulse_start(0);
    budget = 1000;
    n = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      o = cur();
      if (o !== last) begin
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL launch_ev%0d: got st=%0d y=%0d cnt=%0d busy=%0d, want st=%0d y=%0d cnt=%0d busy=%0d",
                   n, o.st, o.y, o.cnt, o.bsy, e.st, e.y, e.cnt, e.bsy);
        end
        n++;
        last = o;
      end
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL launch_timeout: %0d events still pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_stop();
    int changes;
    checks++;
    if (busy !== 1'b0 || y_pos !== 10'd20) begin
      failures++;
      $display("FAIL stop_rest: got busy=%0d y=%0d, want busy=0 y=20", busy, y_pos);
    end
    checks++;
    if (!(bounce_cnt > 8'd1)) begin
      failures++;
      $display("FAIL stop_bounces: got bounce_cnt=%0d, want >1", bounce_cnt);
    end
    changes = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (y_pos !== 10'd20 || busy !== 1'b0) changes++;
    end
    checks++;
    if (changes != 0) begin
      failures++;
      $display("FAIL stop_still: got %0d cycles with motion, want 0", changes);
    end
  endtask

  task automatic test_clamp();
    ev_t o, e;
    int  budget, n;
    exp_q.delete();
    push(ST_DOWN, 20, 0);
    push(ST_BOTTOM, 20, 0);
    push(ST_BOUNCE, 20, 0);
    push(ST_IDLE, 20, 1);
    last = cur();
    pulse_start(30);
    budget = 200;
    n = 0;
    while (exp_q.size() > 0 && budget > 0) begin
      o = cur();
      if (o !== last) begin
        e = exp_q.pop_front();
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL clamp_ev%0d: got st=%0d y=%0d cnt=%0d busy=%0d, want st=%0d y=%0d cnt=%0d busy=%0d",
                   n, o.st, o.y, o.cnt, o.bsy, e.st, e.y, e.cnt, e.bsy);
        end
        n++;
        last = o;
      end
      @(negedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL clamp_timeout: %0d events still pending, want 0", exp_q.size());
    end
  endtask

  task automatic test_start_busy();
    ev_t o, e;
    int  budget, n;
    exp_q.delete();
    push(ST_DOWN, 0, 0);    push(ST_DOWN, 1, 0);    push(ST_DOWN, 3, 0);
    push(ST_DOWN, 6, 0);    push(ST_DOWN, 10, 0);   push(ST_DOWN, 15, 0);
    push(ST_BOTTOM, 20, 0); push(ST_BOUNCE, 20, 0); push(ST_UP, 20, 1);
    push(ST_UP, 17, 1);
    last = cur();
    pulse_start(0);
    for (int phase = 0; phase < 2; phase++) begin
      budget = 500;
      n = 0;
      while (exp_q.size() > 0 && budget > 0) begin
        o = cur();
        if (o !== last) begin
          e = exp_q.pop_front();
          checks++;
          if (o !== e) begin
            failures++;
            $display("FAIL busy_start_p%0d_ev%0d: got st=%0d y=%0d cnt=%0d busy=%0d, want st=%0d y=%0d cnt=%0d busy=%0d",
                     phase, n, o.st, o.y, o.cnt, o.bsy, e.st, e.y, e.cnt, e.bsy);
          end
          n++;
          last = o;
        end
        @(negedge clk);
        budget--;
      end
      if (exp_q.size() != 0) begin
        checks++;
        failures++;
        $display("FAIL busy_start_timeout_p%0d: %0d events pending, want 0", phase, exp_q.size());
        exp_q.delete();
      end
      if (phase == 0) begin
        // Mid-UP at y=17; a launch request arrives with y_init=5.
        pulse_start(5);
`ifdef BOUNCE_RESTART_EN
        o = cur();
        checks++;
        if (o !== mk(ST_DOWN, 5, 0)) begin
          failures++;
          $display("FAIL restart_load: got st=%0d y=%0d cnt=%0d busy=%0d, want st=1 y=5 cnt=0 busy=1",
                   o.st, o.y, o.cnt, o.bsy);
        end
        last = o;
        push(ST_DOWN, 6, 0);
        push(ST_DOWN, 8, 0);
`else
        push(ST_UP, 15, 1);
        push(ST_UP, 14, 1);
        push(ST_DOWN, 14, 1);
`endif
      end
    end
  endtask

  task automatic test_reset_midflight();
    ev_t o;
    int  budget;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start(0);
    budget = 200;
    while (!(y_pos == 10'd6 && state_o == ST_DOWN) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL midreset_reach: got y=%0d st=%0d, want y=6 in DOWN", y_pos, state_o);
    end
    #1 rst = 1'b1;
    #1 o = cur();
    checks++;
    if (o !== mk(ST_IDLE, 0, 0)) begin
      failures++;
      $display("FAIL midreset_async: got st=%0d y=%0d cnt=%0d busy=%0d, want st=0 y=0 cnt=0 busy=0",
               o.st, o.y, o.cnt, o.bsy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    o = cur();
    checks++;
    if (o !== mk(ST_IDLE, 0, 0)) begin
      failures++;
      $display("FAIL midreset_stays_idle: got st=%0d y=%0d cnt=%0d busy=%0d, want idle at 0",
               o.st, o.y, o.cnt, o.bsy);
    end
  endtask

  initial begin
    test_reset();
    test_launch();
    test_stop();
    test_clamp();
    test_start_busy();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
